// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtag_pkg
// Description : Shared TAP state encoding and instruction constants.
// Revision    : 1.0 - initial release
// ============================================================================
package jtag_pkg;

    localparam int IR_WIDTH = 2;

    localparam logic [IR_WIDTH-1:0] INST_BSR = 2'b00;
    localparam logic [IR_WIDTH-1:0] INST_ISR = 2'b10;
    localparam logic [IR_WIDTH-1:0] INST_BYP = 2'b11;

    // IEEE 1149.1 conventional TAP state codes
    typedef enum logic [3:0] {
        TAP_EX2DR   = 4'h0,
        TAP_EX1DR   = 4'h1,
        TAP_SHDR    = 4'h2,
        TAP_PAUSEDR = 4'h3,
        TAP_SELIR   = 4'h4,
        TAP_UPDDR   = 4'h5,
        TAP_CAPDR   = 4'h6,
        TAP_SELDR   = 4'h7,
        TAP_EX2IR   = 4'h8,
        TAP_EX1IR   = 4'h9,
        TAP_SHIR    = 4'hA,
        TAP_PAUSEIR = 4'hB,
        TAP_RTI     = 4'hC,
        TAP_UPDIR   = 4'hD,
        TAP_CAPIR   = 4'hE,
        TAP_TLR     = 4'hF
    } tap_state_t;

endpackage
`default_nettype wire

// File: rtl/jtag_ir.sv
`default_nettype none
// ============================================================================
// Module      : jtag_ir
// Description : Instruction register: capture/shift stage plus update latch.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_ir
    import jtag_pkg::*;
#(
    parameter logic [IR_WIDTH-1:0] IR_RESET   = 2'b11,
    parameter logic [IR_WIDTH-1:0] IR_CAPTURE = 2'b01
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_capture,
    input  logic                i_shift,
    input  logic                i_update,
    input  logic                i_tlr,
    input  logic                i_tdi,
    output logic [IR_WIDTH-1:0] o_inst,
    output logic                o_lsb
);

    logic [IR_WIDTH-1:0] r_stage;
    logic [IR_WIDTH-1:0] r_inst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage <= IR_CAPTURE;
            r_inst  <= IR_RESET;
        end else begin
            if (i_capture)
                r_stage <= IR_CAPTURE;
            else if (i_shift)
                r_stage <= {i_tdi, r_stage[IR_WIDTH-1:1]};

            // Test-Logic-Reset wins so BYPASS is restored without an IR scan
            if (i_tlr)
                r_inst <= IR_RESET;
            else if (i_update)
                r_inst <= r_stage;
        end
    end

    assign o_inst = r_inst;
    assign o_lsb  = r_stage[0];

endmodule
`default_nettype wire

// File: rtl/jtag_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_ctrl
// Description : IEEE 1149.1 TAP controller with bypass bit and TDO select.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter logic [IR_WIDTH-1:0] IR_RESET   = 2'b11,
    parameter logic [IR_WIDTH-1:0] IR_CAPTURE = 2'b01
) (
    input  logic                TCLK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    input  logic                TDO_BSR,
    input  logic                TDO_ISR,
    output logic                TDO,
    output logic                TDO_EN,
    output logic [IR_WIDTH-1:0] inst,
    output logic                clockdr_bs,
    output logic                updatedr_bs,
    output logic                shiftdr_bs,
    output logic                clockdr_is,
    output logic                updatedr_is,
    output logic                shiftdr_is,
    output logic [3:0]          tap_state
);

    tap_state_t          r_state;
    tap_state_t          w_next;
    logic                r_bypass;
    logic                w_ir_lsb;
    logic                w_tdo;
    logic [IR_WIDTH-1:0] w_inst;
    logic                w_sel_bs;
    logic                w_sel_is;
    logic                w_sel_byp;

    always_ff @(posedge TCLK) begin
        if (TRST)
            r_state <= TAP_TLR;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            TAP_TLR:     w_next = TMS ? TAP_TLR     : TAP_RTI;
            TAP_RTI:     w_next = TMS ? TAP_SELDR   : TAP_RTI;
            TAP_SELDR:   w_next = TMS ? TAP_SELIR   : TAP_CAPDR;
            TAP_CAPDR:   w_next = TMS ? TAP_EX1DR   : TAP_SHDR;
            TAP_SHDR:    w_next = TMS ? TAP_EX1DR   : TAP_SHDR;
            TAP_EX1DR:   w_next = TMS ? TAP_UPDDR   : TAP_PAUSEDR;
            TAP_PAUSEDR: w_next = TMS ? TAP_EX2DR   : TAP_PAUSEDR;
            TAP_EX2DR:   w_next = TMS ? TAP_UPDDR   : TAP_SHDR;
            TAP_UPDDR:   w_next = TMS ? TAP_SELDR   : TAP_RTI;
            TAP_SELIR:   w_next = TMS ? TAP_TLR     : TAP_CAPIR;
            TAP_CAPIR:   w_next = TMS ? TAP_EX1IR   : TAP_SHIR;
            TAP_SHIR:    w_next = TMS ? TAP_EX1IR   : TAP_SHIR;
            TAP_EX1IR:   w_next = TMS ? TAP_UPDIR   : TAP_PAUSEIR;
            TAP_PAUSEIR: w_next = TMS ? TAP_EX2IR   : TAP_PAUSEIR;
            TAP_EX2IR:   w_next = TMS ? TAP_UPDIR   : TAP_SHIR;
            TAP_UPDIR:   w_next = TMS ? TAP_SELDR   : TAP_RTI;
            default:     w_next = TAP_TLR;
        endcase
    end

    jtag_ir #(
        .IR_RESET   (IR_RESET),
        .IR_CAPTURE (IR_CAPTURE)
    ) u_ir (
        .clk        (TCLK),
        .rst        (TRST),
        .i_capture  (r_state == TAP_CAPIR),
        .i_shift    (r_state == TAP_SHIR),
        .i_update   (r_state == TAP_UPDIR),
        .i_tlr      (r_state == TAP_TLR),
        .i_tdi      (TDI),
        .o_inst     (w_inst),
        .o_lsb      (w_ir_lsb)
    );

    assign w_sel_bs  = (w_inst == INST_BSR);
    assign w_sel_is  = (w_inst == INST_ISR);
    assign w_sel_byp = w_inst[0];

    always_ff @(posedge TCLK) begin
        if (TRST)
            r_bypass <= 1'b0;
        else if (w_sel_byp) begin
            if (r_state == TAP_CAPDR)
                r_bypass <= 1'b0;
            else if (r_state == TAP_SHDR)
                r_bypass <= TDI;
        end
    end

    always_comb begin
        w_tdo = 1'b0;
        if (r_state == TAP_SHIR)
            w_tdo = w_ir_lsb;
        else if (r_state == TAP_SHDR) begin
            case (w_inst)
                INST_BSR: w_tdo = TDO_BSR;
                INST_ISR: w_tdo = TDO_ISR;
                default:  w_tdo = r_bypass;
            endcase
        end
    end

    assign TDO         = w_tdo;
    assign TDO_EN      = (r_state == TAP_SHIR) || (r_state == TAP_SHDR);
    assign inst        = w_inst;
    assign clockdr_bs  = w_sel_bs && ((r_state == TAP_CAPDR) || (r_state == TAP_SHDR));
    assign shiftdr_bs  = w_sel_bs && (r_state == TAP_SHDR);
    assign updatedr_bs = w_sel_bs && (r_state == TAP_UPDDR);
    assign clockdr_is  = w_sel_is && ((r_state == TAP_CAPDR) || (r_state == TAP_SHDR));
    assign shiftdr_is  = w_sel_is && (r_state == TAP_SHDR);
    assign updatedr_is = w_sel_is && (r_state == TAP_UPDDR);
    assign tap_state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_tap_ctrl
// Description : Randomized TAP stimulus checked against a table-driven model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_ctrl;
    import jtag_pkg::*;

    logic       TCLK = 1'b0;
    logic       TRST = 1'b1;
    logic       TMS = 1'b1;
    logic       TDI = 1'b0;
    logic       TDO_BSR = 1'b0;
    logic       TDO_ISR = 1'b0;
    logic       TDO, TDO_EN;
    logic [1:0] inst;
    logic       clockdr_bs, updatedr_bs, shiftdr_bs;
    logic       clockdr_is, updatedr_is, shiftdr_is;
    logic [3:0] tap_state;

    jtag_tap_ctrl #(.IR_RESET(2'b11), .IR_CAPTURE(2'b01)) dut (
        .TCLK(TCLK), .TRST(TRST), .TMS(TMS), .TDI(TDI),
        .TDO_BSR(TDO_BSR), .TDO_ISR(TDO_ISR), .TDO(TDO), .TDO_EN(TDO_EN),
        .inst(inst),
        .clockdr_bs(clockdr_bs), .updatedr_bs(updatedr_bs), .shiftdr_bs(shiftdr_bs),
        .clockdr_is(clockdr_is), .updatedr_is(updatedr_is), .shiftdr_is(shiftdr_is),
        .tap_state(tap_state)
    );

    always #5 TCLK = ~TCLK;

    // Model states numbered in the order the standard lists them
    localparam int C_TLR = 0,  C_RTI = 1,   C_SELDR = 2,  C_CAPDR = 3,
                   C_SHDR = 4, C_EX1DR = 5, C_PAUSEDR = 6, C_EX2DR = 7,
                   C_UPDDR = 8, C_SELIR = 9, C_CAPIR = 10, C_SHIR = 11,
                   C_EX1IR = 12, C_PAUSEIR = 13, C_EX2IR = 14, C_UPDIR = 15;

    int         nxt0 [16];
    int         nxt1 [16];
    tap_state_t code_of [16];

    int         m_state;
    logic [1:0] m_inst;
    logic [1:0] m_ir;
    logic       m_byp;

    int errors = 0;
    int checks = 0;
    int n_clk_bs, n_sh_bs, n_up_bs, n_is;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = C_TLR;
        m_inst  = 2'b11;
        m_ir    = 2'b01;
        m_byp   = 1'b0;
    endtask

    task automatic check_outputs();
        logic dr_cap, dr_sh, dr_up, e_tdo;
        dr_cap = (m_state == C_CAPDR) || (m_state == C_SHDR);
        dr_sh  = (m_state == C_SHDR);
        dr_up  = (m_state == C_UPDDR);
        if (m_state == C_SHIR)      e_tdo = m_ir[0];
        else if (!dr_sh)            e_tdo = 1'b0;
        else if (m_inst == 2'b00)   e_tdo = TDO_BSR;
        else if (m_inst == 2'b10)   e_tdo = TDO_ISR;
        else                        e_tdo = m_byp;
        check("tap_state", tap_state, code_of[m_state]);
        check("inst", inst, m_inst);
        check("tdo", TDO, e_tdo);
        check("tdo_en", TDO_EN, (m_state == C_SHIR) || dr_sh);
        check("clockdr_bs", clockdr_bs, dr_cap && m_inst == 2'b00);
        check("shiftdr_bs", shiftdr_bs, dr_sh && m_inst == 2'b00);
        check("updatedr_bs", updatedr_bs, dr_up && m_inst == 2'b00);
        check("clockdr_is", clockdr_is, dr_cap && m_inst == 2'b10);
        check("shiftdr_is", shiftdr_is, dr_sh && m_inst == 2'b10);
        check("updatedr_is", updatedr_is, dr_up && m_inst == 2'b10);
        n_clk_bs += int'(clockdr_bs);
        n_sh_bs  += int'(shiftdr_bs);
        n_up_bs  += int'(updatedr_bs);
        n_is     += int'(clockdr_is) + int'(shiftdr_is) + int'(updatedr_is);
    endtask

    // Drive one cycle: check the current state, clock it, advance the model
    task automatic step(input logic tms, input logic tdi, input logic trst = 1'b0);
        logic [1:0] n_inst, n_ir;
        logic       n_byp;
        TMS = tms; TDI = tdi; TRST = trst;
        TDO_BSR = 1'($urandom); TDO_ISR = 1'($urandom);
        #1;
        check_outputs();
        @(posedge TCLK);
        if (trst) model_reset();
        else begin
            n_inst = m_inst; n_ir = m_ir; n_byp = m_byp;
            if (m_state == C_CAPIR) n_ir = 2'b01;
            if (m_state == C_SHIR)  n_ir = {tdi, m_ir[1]};
            if (m_state == C_UPDIR) n_inst = m_ir;
            if (m_state == C_TLR)   n_inst = 2'b11;
            if (m_inst[0] && m_state == C_CAPDR) n_byp = 1'b0;
            if (m_inst[0] && m_state == C_SHDR)  n_byp = tdi;
            m_inst = n_inst; m_ir = n_ir; m_byp = n_byp;
            m_state = tms ? nxt1[m_state] : nxt0[m_state];
        end
        #1;
    endtask

    task automatic ir_scan(input logic [1:0] val);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        step(0, val[0]); step(1, val[1]); step(1, 0); step(0, 0);
    endtask

    // RTI -> CapDR -> 3x ShDR -> Ex1DR -> UpdDR -> RTI; records TDO per shift
    task automatic dr_scan(input logic [2:0] tdi_seq, output logic [2:0] tdo_seq);
        n_clk_bs = 0; n_sh_bs = 0; n_up_bs = 0; n_is = 0;
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 3; i++) begin
            TDO_BSR = 1'($urandom); TDO_ISR = 1'($urandom);
            tdo_seq[i] = (inst == 2'b00) ? TDO_BSR : (inst == 2'b10) ? TDO_ISR : TDO;
            step(i == 2, tdi_seq[i]);
        end
        step(1, 0); step(0, 0);
    endtask

    logic [2:0] tdo_seq;
    logic       ir_tdo0;

    initial begin
        nxt0 = '{C_RTI, C_RTI, C_CAPDR, C_SHDR, C_SHDR, C_PAUSEDR, C_PAUSEDR, C_SHDR,
                 C_RTI, C_CAPIR, C_SHIR, C_SHIR, C_PAUSEIR, C_PAUSEIR, C_SHIR, C_RTI};
        nxt1 = '{C_TLR, C_SELDR, C_SELIR, C_EX1DR, C_EX1DR, C_UPDDR, C_EX2DR, C_UPDDR,
                 C_SELDR, C_TLR, C_EX1IR, C_EX1IR, C_UPDIR, C_EX2IR, C_UPDIR, C_SELDR};
        code_of = '{TAP_TLR, TAP_RTI, TAP_SELDR, TAP_CAPDR, TAP_SHDR, TAP_EX1DR,
                    TAP_PAUSEDR, TAP_EX2DR, TAP_UPDDR, TAP_SELIR, TAP_CAPIR, TAP_SHIR,
                    TAP_EX1IR, TAP_PAUSEIR, TAP_EX2IR, TAP_UPDIR};
        n_clk_bs = 0; n_sh_bs = 0; n_up_bs = 0; n_is = 0;

        repeat (2) @(posedge TCLK);
        #1;
        model_reset();

        // Reset then five TMS=1 cycles
        repeat (5) step(1, 0);
        check("tlr_code", tap_state, 4'hF);
        check("tlr_inst", inst, 2'b11);
        step(0, 0);

        // IR scan loading 00, watching the captured bits come out
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        ir_tdo0 = TDO;
        check("ir_tdo_first", ir_tdo0, 1'b1);
        step(0, 0);
        check("ir_tdo_second", TDO, 1'b0);
        step(1, 0); step(1, 0); step(0, 0);
        check("ir_load_bsr", inst, 2'b00);

        // Boundary-chain DR scan
        dr_scan(3'b101, tdo_seq);
        check("bs_clockdr_cycles", n_clk_bs, 4);
        check("bs_shiftdr_cycles", n_sh_bs, 3);
        check("bs_updatedr_cycles", n_up_bs, 1);
        check("bs_is_quiet", n_is, 0);

        // Internal-chain DR scan
        ir_scan(2'b10);
        check("ir_load_isr", inst, 2'b10);
        dr_scan(3'b011, tdo_seq);
        check("is_bs_quiet", n_clk_bs + n_sh_bs + n_up_bs, 0);
        check("is_active_cycles", n_is, 8);

        // Bypass: one-cycle delay of TDI
        ir_scan(2'b11);
        dr_scan(3'b101, tdo_seq);
        check("byp_tdo_seq", tdo_seq, 3'b010);
        check("byp_controls", n_clk_bs + n_sh_bs + n_up_bs + n_is, 0);

        // Reset in the middle of a boundary shift
        ir_scan(2'b00);
        step(1, 0); step(0, 0); step(0, 0);
        check("mid_shift_bs", shiftdr_bs, 1'b1);
        step(0, 1, 1);
        check("rst_state", tap_state, 4'hF);
        check("rst_inst", inst, 2'b11);
        check("rst_shiftdr_bs", shiftdr_bs, 1'b0);
        check("rst_tdo_en", TDO_EN, 1'b0);

        // Random walk with occasional resets
        for (int n = 0; n < 3000; n++)
            step(1'($urandom), 1'($urandom), ($urandom_range(0, 63) == 0));
        step(1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
